// File: rtl/lfsr_pkg.sv
// ---------------------------------------------------------------------------
// lfsr_pkg
//   Shared definitions for the 4-bit PRBS generator / checker pair.
//   Both ends import lfsr_next so the polynomial can never diverge.
//   Contents:
//     LFSR_W       word width of the PRBS stream
//     lfsr_next()  next-word function, nxt(q) = {q[2:0], q[3]^q[2]}
//     chk_state_t  checker FSM states (HUNT, VERIFY, LOCKED)
// ---------------------------------------------------------------------------
package lfsr_pkg;

  localparam int LFSR_W = 4;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } chk_state_t;

  // Period-15 maximal-length sequence; all-zero is the lock-up word and illegal.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] q);
    return {q[2:0], q[3] ^ q[2]};
  endfunction

endpackage

// File: rtl/lfsr_seq_checker.sv
// ---------------------------------------------------------------------------
// lfsr_seq_checker
//   Receive-side checker for the 4-bit PRBS stream. Hunts for a non-zero seed,
//   verifies LOCK_CNT consecutive consistent words, then flywheels its own
//   prediction and counts mismatching words. UNLOCK_CNT consecutive misses
//   drop lock. All outputs are registered.
// Ports:
//   clk          in   rising-edge clock
//   preset       in   asynchronous active-high reset
//   code_valid   in   code holds a new stream word this cycle
//   code         in   received PRBS word (LFSR_W bits)
//   clear_count  in   synchronous clear of err_count (wins over an increment)
//   locked       out  checker is locked to the stream
//   err_pulse    out  one-cycle pulse: last valid word mismatched while locked
//   err_count    out  saturating count of mismatches while locked
//   zero_seen    out  sticky flag: an all-zero word was received
// ---------------------------------------------------------------------------
module lfsr_seq_checker
  import lfsr_pkg::*;
#(
  parameter int LOCK_CNT   = 4,
  parameter int UNLOCK_CNT = 3,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              preset,
  input  logic              code_valid,
  input  logic [LFSR_W-1:0] code,
  input  logic              clear_count,
  output logic              locked,
  output logic              err_pulse,
  output logic [CNT_W-1:0]  err_count,
  output logic              zero_seen
);

  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int UW = $clog2(UNLOCK_CNT + 1);
  localparam logic [MW-1:0] LOCK_VAL   = MW'(LOCK_CNT);
  localparam logic [UW-1:0] UNLOCK_VAL = UW'(UNLOCK_CNT);

  chk_state_t        state_q,     state_d;
  logic [LFSR_W-1:0] predict_q,   predict_d;
  logic [MW-1:0]     match_cnt_q, match_cnt_d;
  logic [UW-1:0]     miss_cnt_q,  miss_cnt_d;
  logic              locked_q,    locked_d;
  logic              err_pulse_q, err_pulse_d;
  logic [CNT_W-1:0]  err_count_q, err_count_d;
  logic              zero_seen_q, zero_seen_d;

  logic              code_zero_s;
  logic              code_match_s;

  assign code_zero_s  = (code == {LFSR_W{1'b0}});
  assign code_match_s = (code == predict_q);

  // Next-state decode for the hunt/verify/lock FSM and its counters.
  always_comb begin
    state_d     = state_q;
    predict_d   = predict_q;
    match_cnt_d = match_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    err_pulse_d = 1'b0;
    err_count_d = err_count_q;
    zero_seen_d = zero_seen_q;

    if (code_valid) begin
      if (code_zero_s) begin
        zero_seen_d = 1'b1;
      end else begin
        zero_seen_d = zero_seen_q;
      end

      case (state_q)
        HUNT: begin
          if (!code_zero_s) begin
            predict_d   = lfsr_next(code);
            match_cnt_d = {{(MW-1){1'b0}}, 1'b1};
            state_d     = VERIFY;
          end else begin
            state_d = HUNT;
          end
        end
        VERIFY: begin
          if (code_match_s) begin
            predict_d   = lfsr_next(code);
            match_cnt_d = match_cnt_q + {{(MW-1){1'b0}}, 1'b1};
            if (match_cnt_d == LOCK_VAL) begin
              state_d    = LOCKED;
              miss_cnt_d = {UW{1'b0}};
            end else begin
              state_d = VERIFY;
            end
          end else if (!code_zero_s) begin
            // Inconsistent but legal word: treat it as a fresh seed.
            predict_d   = lfsr_next(code);
            match_cnt_d = {{(MW-1){1'b0}}, 1'b1};
          end else begin
            state_d = HUNT;
          end
        end
        LOCKED: begin
          // Flywheel: once locked the prediction never follows the data.
          predict_d = lfsr_next(predict_q);
          if (code_match_s) begin
            miss_cnt_d = {UW{1'b0}};
          end else begin
            err_pulse_d = 1'b1;
            if (err_count_q != {CNT_W{1'b1}}) begin
              err_count_d = err_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
              err_count_d = err_count_q;
            end
            miss_cnt_d = miss_cnt_q + {{(UW-1){1'b0}}, 1'b1};
            if (miss_cnt_d == UNLOCK_VAL) begin
              state_d     = HUNT;
              match_cnt_d = {MW{1'b0}};
            end else begin
              state_d = LOCKED;
            end
          end
        end
        default: begin
          state_d = HUNT;
        end
      endcase
    end else begin
      state_d = state_q;
    end

    if (clear_count) begin
      err_count_d = {CNT_W{1'b0}};
    end else begin
      err_count_d = err_count_d;
    end

    locked_d = (state_d == LOCKED);
  end

  // State, counter and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge preset) begin
    if (preset) begin
      state_q     <= HUNT;
      predict_q   <= {LFSR_W{1'b0}};
      match_cnt_q <= {MW{1'b0}};
      miss_cnt_q  <= {UW{1'b0}};
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      err_count_q <= {CNT_W{1'b0}};
      zero_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      predict_q   <= predict_d;
      match_cnt_q <= match_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      locked_q    <= locked_d;
      err_pulse_q <= err_pulse_d;
      err_count_q <= err_count_d;
      zero_seen_q <= zero_seen_d;
    end
  end

  assign locked    = locked_q;
  assign err_pulse = err_pulse_q;
  assign err_count = err_count_q;
  assign zero_seen = zero_seen_q;

endmodule

// File: tb/tb_lfsr_seq_checker.sv
// ---------------------------------------------------------------------------
// tb_lfsr_seq_checker
//   Self-checking bench for lfsr_seq_checker. The reference model tracks the
//   stream as a position in the 15-entry PRBS table rather than shifting bits.
// ---------------------------------------------------------------------------
module tb_lfsr_seq_checker;

  logic        clk = 1'b0;
  logic        preset;
  logic        code_valid;
  logic [3:0]  code;
  logic        clear_count;
  logic        locked;
  logic        err_pulse;
  logic [15:0] err_count;
  logic        zero_seen;

  int n_checks = 0;
  int n_errors = 0;

  logic [3:0] seq [15] = '{4'b0001, 4'b0010, 4'b0100, 4'b1001, 4'b0011,
                           4'b0110, 4'b1101, 4'b1010, 4'b0101, 4'b1011,
                           4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000};
  int pos;  // index of the next clean stream word

  // model: mode 0=searching for seed, 1=verifying, 2=locked
  int         m_mode;
  logic [3:0] m_pred;
  int         m_run;
  int         m_miss;
  int         m_cnt;
  bit         m_pulse;
  bit         m_zero;

  lfsr_seq_checker dut (
    .clk        (clk),
    .preset     (preset),
    .code_valid (code_valid),
    .code       (code),
    .clear_count(clear_count),
    .locked     (locked),
    .err_pulse  (err_pulse),
    .err_count  (err_count),
    .zero_seen  (zero_seen)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] succ(input logic [3:0] w);
    for (int i = 0; i < 15; i++) begin
      if (seq[i] == w) return seq[(i + 1) % 15];
    end
    return 4'b0000;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_pred = 4'b0000; m_run = 0; m_miss = 0;
    m_cnt = 0; m_pulse = 0; m_zero = 0;
  endtask

  task automatic model_step(input bit v, input logic [3:0] c, input bit clr);
    m_pulse = 0;
    if (v) begin
      if (c == 4'b0000) m_zero = 1;
      if (m_mode == 2) begin
        if (c != m_pred) begin
          m_pulse = 1;
          if (m_cnt < 65535) m_cnt++;
          m_miss++;
          if (m_miss == 3) m_mode = 0;
        end else begin
          m_miss = 0;
        end
        m_pred = succ(m_pred);
      end else if (m_mode == 1 && c == m_pred) begin
        m_run++;
        m_pred = succ(c);
        if (m_run == 4) begin m_mode = 2; m_miss = 0; end
      end else if (c != 4'b0000) begin
        m_mode = 1; m_run = 1; m_pred = succ(c);
      end else begin
        m_mode = 0;
      end
    end
    if (clr) m_cnt = 0;
  endtask

  task automatic drive(input bit v, input logic [3:0] c, input bit clr);
    @(negedge clk);
    code_valid = v; code = c; clear_count = clr;
    model_step(v, c, clr);
    @(posedge clk);
    #1;
  endtask

  // Send the next stream word, optionally corrupted by a non-zero xor mask.
  task automatic send(input logic [3:0] mask, input bit clr);
    drive(1'b1, seq[pos] ^ mask, clr);
    pos = (pos + 1) % 15;
  endtask

  task automatic do_reset();
    @(negedge clk);
    preset = 1'b1; code_valid = 1'b0; code = 4'b0000; clear_count = 1'b0;
    model_reset();
    @(negedge clk);
    preset = 1'b0;
    pos = 0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (locked !== 1'b0 || err_pulse !== 1'b0 || err_count !== 16'd0 || zero_seen !== 1'b0) begin
      n_errors++;
      $display("FAIL reset: locked=%b pulse=%b cnt=%0d zero=%b, want all 0",
               locked, err_pulse, err_count, zero_seen);
    end
  endtask

  task automatic test_clean_lock();
    do_reset();
    for (int i = 0; i < 49; i++) begin
      send(4'b0000, 1'b0);
      n_checks++;
      if (locked !== (i >= 3) || err_count !== 16'd0 || err_pulse !== 1'b0) begin
        n_errors++;
        $display("FAIL clean_lock word %0d: locked=%b cnt=%0d pulse=%b, want locked=%b cnt=0",
                 i, locked, err_count, err_pulse, (i >= 3));
      end
    end
  endtask

  task automatic test_single_error();
    // stream is locked; advance until next word is 0110 (index 5)
    while (pos != 5) send(4'b0000, 1'b0);
    send(4'b0001, 1'b0);  // 0110 -> 0111
    n_checks++;
    if (err_pulse !== 1'b1 || err_count !== 16'd1 || locked !== 1'b1) begin
      n_errors++;
      $display("FAIL single_error: pulse=%b cnt=%0d locked=%b, want 1/1/1", err_pulse, err_count, locked);
    end
    for (int i = 0; i < 4; i++) begin
      send(4'b0000, 1'b0);
      n_checks++;
      if (err_pulse !== 1'b0 || err_count !== 16'd1 || locked !== 1'b1) begin
        n_errors++;
        $display("FAIL single_error_after %0d: pulse=%b cnt=%0d locked=%b, want 0/1/1",
                 i, err_pulse, err_count, locked);
      end
    end
  endtask

  task automatic test_loss_of_lock();
    send(4'b0000, 1'b1);  // clear counter on a clean word
    for (int i = 0; i < 3; i++) begin
      send(4'(1 + $urandom_range(0, 14)), 1'b0);
      n_checks++;
      if (err_pulse !== 1'b1 || err_count !== 16'(i + 1) || locked !== (i < 2)) begin
        n_errors++;
        $display("FAIL loss_of_lock miss %0d: pulse=%b cnt=%0d locked=%b, want 1/%0d/%b",
                 i, err_pulse, err_count, locked, i + 1, (i < 2));
      end
    end
    for (int i = 0; i < 4; i++) begin
      send(4'b0000, 1'b0);
      n_checks++;
      if (locked !== (i == 3) || err_count !== 16'd3) begin
        n_errors++;
        $display("FAIL relock word %0d: locked=%b cnt=%0d, want %b/3", i, locked, err_count, (i == 3));
      end
    end
  endtask

  task automatic test_gaps_and_false_seeds();
    logic [3:0] fs [8] = '{4'b0001, 4'b0010, 4'b1111, 4'b0100,
                           4'b1111, 4'b1110, 4'b1100, 4'b1000};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      send(4'b0000, 1'b0);
      drive(1'b0, 4'($urandom_range(0, 15)), 1'b0);
      n_checks++;
      if (locked !== (i == 3) || err_count !== 16'd0 || err_pulse !== 1'b0) begin
        n_errors++;
        $display("FAIL gaps word %0d: locked=%b cnt=%0d pulse=%b, want %b/0/0",
                 i, locked, err_count, err_pulse, (i == 3));
      end
    end
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, fs[i], 1'b0);
      n_checks++;
      if (locked !== (i == 7)) begin
        n_errors++;
        $display("FAIL false_seed word %0d: locked=%b, want %b", i, locked, (i == 7));
      end
    end
  endtask

  task automatic test_zero_and_clear();
    do_reset();
    drive(1'b1, 4'b0000, 1'b0);
    n_checks++;
    if (zero_seen !== 1'b1 || locked !== 1'b0) begin
      n_errors++;
      $display("FAIL zero_in_hunt: zero=%b locked=%b, want 1/0", zero_seen, locked);
    end
    for (int i = 0; i < 4; i++) send(4'b0000, 1'b0);
    send(4'b0010, 1'b0);
    send(4'b0000, 1'b0);
    n_checks++;
    if (err_count !== 16'd1 || locked !== 1'b1) begin
      n_errors++;
      $display("FAIL pre_clear: cnt=%0d locked=%b, want 1/1", err_count, locked);
    end
    send(4'b0100, 1'b1);
    n_checks++;
    if (err_count !== 16'd0 || err_pulse !== 1'b1 || zero_seen !== 1'b1) begin
      n_errors++;
      $display("FAIL clear_with_error: cnt=%0d pulse=%b zero=%b, want 0/1/1", err_count, err_pulse, zero_seen);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 4; i++) send(4'b0000, 1'b0);
    for (int i = 0; i < 5; i++) begin
      send(4'b1000, 1'b0);
      send(4'b0000, 1'b0);
    end
    n_checks++;
    if (err_count !== 16'd5 || locked !== 1'b1) begin
      n_errors++;
      $display("FAIL pre_async: cnt=%0d locked=%b, want 5/1", err_count, locked);
    end
    @(negedge clk);
    #2;
    preset = 1'b1;
    #1;
    n_checks++;
    if (locked !== 1'b0 || err_count !== 16'd0 || err_pulse !== 1'b0) begin
      n_errors++;
      $display("FAIL async_reset: locked=%b cnt=%0d pulse=%b, want 0/0/0", locked, err_count, err_pulse);
    end
    model_reset();
    @(negedge clk);
    preset = 1'b0;
    pos = 0;
  endtask

  task automatic test_random();
    logic [3:0] mask;
    bit v, clr;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      v    = ($urandom_range(0, 9) != 0);
      clr  = ($urandom_range(0, 199) == 0);
      mask = ($urandom_range(0, 19) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
      if ($urandom_range(0, 499) == 0) pos = $urandom_range(0, 14);
      if (v) send(mask, clr);
      else   drive(1'b0, 4'($urandom_range(0, 15)), clr);
      n_checks++;
      if (locked !== (m_mode == 2) || err_pulse !== m_pulse ||
          err_count !== 16'(m_cnt) || zero_seen !== m_zero) begin
        n_errors++;
        $display("FAIL random cycle %0d: locked=%b pulse=%b cnt=%0d zero=%b, want %b/%b/%0d/%b",
                 i, locked, err_pulse, err_count, zero_seen, (m_mode == 2), m_pulse, m_cnt, m_zero);
      end
    end
  endtask

  initial begin
    preset = 1'b1; code_valid = 1'b0; code = 4'b0000; clear_count = 1'b0;
    model_reset();
    test_reset();
    test_clean_lock();
    test_single_error();
    test_loss_of_lock();
    test_gaps_and_false_seeds();
    test_zero_and_clear();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
